// File: rtl/ls74157_arbiter.sv
// Two-requester arbiter for a shared ls74157 quad 2:1 mux: drives select/enable_n,
// inserts one dead cycle between owners, rotates priority and bounds hold time.
module ls74157_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       select,
  output logic       enable_n,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  // Handshake: a requester holds req high for the whole transfer, drives the bus
  // only while its grant is high, and stops on the same edge it drops req.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TURN_A = 3'd1,
    S_TURN_B = 3'd2,
    S_OWN_A  = 3'd3,
    S_OWN_B  = 3'd4
  } state_t;

  localparam logic       PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       ptr_q, ptr_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       select_q, select_d;
  logic       enable_n_q, enable_n_d;
  logic       busy_q, busy_d;
  logic       hold_expired;

  // The counter keeps running past the limit, so a late contender still preempts.
  assign hold_expired = PREEMPT_EN && ((hold_q == HOLD_LAST) || (hold_q > HOLD_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_q     <= 8'd0;
      ptr_q      <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      select_q   <= 1'b0;
      enable_n_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ptr_q      <= ptr_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      select_q   <= select_d;
      enable_n_q <= enable_n_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_a && req_b) state_d = ptr_q ? S_TURN_B : S_TURN_A;
        else if (req_a)     state_d = S_TURN_A;
        else if (req_b)     state_d = S_TURN_B;
      end
      S_TURN_A: begin
        if (req_a)      state_d = S_OWN_A;
        else if (req_b) state_d = S_TURN_B;
        else            state_d = S_IDLE;
      end
      S_TURN_B: begin
        if (req_b)      state_d = S_OWN_B;
        else if (req_a) state_d = S_TURN_A;
        else            state_d = S_IDLE;
      end
      S_OWN_A: begin
        if (!req_a)                     state_d = req_b ? S_TURN_B : S_IDLE;
        else if (hold_expired && req_b) state_d = S_TURN_B;
      end
      S_OWN_B: begin
        if (!req_b)                     state_d = req_a ? S_TURN_A : S_IDLE;
        else if (hold_expired && req_a) state_d = S_TURN_A;
      end
      default: state_d = S_IDLE;
    endcase

    // Entering ownership restarts the hold count and hands priority to the other side.
    hold_d = hold_q;
    ptr_d  = ptr_q;
    if (state_d == S_OWN_A && state_q != S_OWN_A) begin
      hold_d = 8'd0;
      ptr_d  = 1'b1;
    end else if (state_d == S_OWN_B && state_q != S_OWN_B) begin
      hold_d = 8'd0;
      ptr_d  = 1'b0;
    end else if (state_d == state_q && (state_q == S_OWN_A || state_q == S_OWN_B)
                 && hold_q != 8'hFF) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state and registered; select only moves
  // in TURN states, where the mux is already disabled.
  always_comb begin
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    select_d   = select_q;
    enable_n_d = 1'b1;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_TURN_A: select_d = 1'b0;
      S_TURN_B: select_d = 1'b1;
      S_OWN_A: begin
        gnt_a_d    = 1'b1;
        select_d   = 1'b0;
        enable_n_d = 1'b0;
      end
      S_OWN_B: begin
        gnt_b_d    = 1'b1;
        select_d   = 1'b1;
        enable_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign select      = select_q;
  assign enable_n    = enable_n_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ls74157_arbiter.sv
// Bench for ls74157_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=0) share stimulus;
// a reference model fills per-instance expected queues that are drained after each edge.
module tb_ls74157_arbiter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  typedef struct packed {
    logic [1:0] st;
    logic       who;
    logic       ptr;
    logic       sel;
    logic [7:0] cnt;
  } model_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [3:0] da = 4'h0;
  logic [3:0] db = 4'h0;

  logic       ga4, gb4, sel4, enn4, busy4;
  logic       ga0, gb0, sel0, enn0, busy0;
  logic [2:0] dbg4, dbg0;
  logic [4:0] v4, v0;
  logic [3:0] bus4, bus0;

  logic [4:0] exp4_q[$];
  logic [4:0] exp0_q[$];
  model_t     m4, m0;
  logic       psel4, penn4, psel0, penn0;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         ga_cnt4, gb_cnt4, dead_cnt4, ga_cnt0;

  ls74157_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
    .gnt_a(ga4), .gnt_b(gb4), .select(sel4), .enable_n(enn4), .busy(busy4),
    .dbg_state_o(dbg4)
  );

  ls74157_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
    .gnt_a(ga0), .gnt_b(gb0), .select(sel0), .enable_n(enn0), .busy(busy0),
    .dbg_state_o(dbg0)
  );

  assign v4   = {ga4, gb4, sel4, enn4, busy4};
  assign v0   = {ga0, gb0, sel0, enn0, busy0};
  // ls74157 model: disabled output is 0000, otherwise select picks b over a
  assign bus4 = enn4 ? 4'h0 : (sel4 ? db : da);
  assign bus0 = enn0 ? 4'h0 : (sel0 ? db : da);

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_step(model_t m, logic ra, logic rb, int mh);
    model_t n;
    logic   mine, other;
    n     = m;
    mine  = m.who ? rb : ra;
    other = m.who ? ra : rb;
    case (m.st)
      ST_IDLE: if (ra || rb) begin
        n.st  = ST_TURN;
        n.who = (ra && rb) ? m.ptr : rb;
        n.sel = n.who;
      end
      ST_TURN: begin
        if (mine) begin
          n.st  = ST_OWN;
          n.cnt = 8'd0;
          n.ptr = !m.who;
        end else if (other) begin
          n.who = !m.who;
          n.sel = n.who;
        end else n.st = ST_IDLE;
      end
      default: begin
        if (!mine || (mh != 0 && int'(m.cnt) >= mh - 1 && other)) begin
          if (other) begin
            n.st  = ST_TURN;
            n.who = !m.who;
            n.sel = n.who;
          end else n.st = ST_IDLE;
        end else if (m.cnt != 8'hFF) n.cnt = m.cnt + 8'd1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [4:0] model_out(model_t m);
    return {m.st == ST_OWN && !m.who, m.st == ST_OWN && m.who, m.sel,
            m.st != ST_OWN, m.st != ST_IDLE};
  endfunction

  task automatic check_inv(input string sfx, input logic ga, input logic gb, input logic sel,
                           input logic enn, input logic psel, input logic penn,
                           input logic [3:0] bus);
    check_eq({"excl_", sfx}, {7'd0, ga & gb}, 8'd0);
    check_eq({"gnt_en_", sfx}, {7'd0, (ga | gb) & enn}, 8'd0);
    if (sel != psel) check_eq({"sel_dead_", sfx}, {7'd0, enn}, 8'd1);
    if (!enn && !penn) check_eq({"sel_hold_", sfx}, {7'd0, sel}, {7'd0, psel});
    if (ga) check_eq({"mux_a_", sfx}, {4'd0, bus}, {4'd0, da});
    if (gb) check_eq({"mux_b_", sfx}, {4'd0, bus}, {4'd0, db});
  endtask

  task automatic step(input logic ra, input logic rb);
    @(negedge clk);
    reset = 1'b0;
    req_a = ra;
    req_b = rb;
    da    = 4'($urandom_range(0, 15));
    db    = 4'($urandom_range(0, 15));
    m4    = model_step(m4, ra, rb, 4);
    m0    = model_step(m0, ra, rb, 0);
    exp4_q.push_back(model_out(m4));
    exp0_q.push_back(model_out(m0));
    @(posedge clk);
    #1;
    if (exp4_q.size() > 0) check_eq("out_mh4", {3'd0, v4}, {3'd0, exp4_q.pop_front()});
    if (exp0_q.size() > 0) check_eq("out_mh0", {3'd0, v0}, {3'd0, exp0_q.pop_front()});
    check_inv("mh4", ga4, gb4, sel4, enn4, psel4, penn4, bus4);
    check_inv("mh0", ga0, gb0, sel0, enn0, psel0, penn0, bus0);
    psel4 = sel4; penn4 = enn4;
    psel0 = sel0; penn0 = enn0;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_async_mh4", {3'd0, v4}, 8'b0000_0010);
    check_eq("rst_async_mh0", {3'd0, v0}, 8'b0000_0010);
    m4 = '0; m0 = '0;
    psel4 = 1'b0; penn4 = 1'b1;
    psel0 = 1'b0; penn0 = 1'b1;
  endtask

  initial begin
    logic ra, rb;
    m4 = '0; m0 = '0;
    psel4 = 1'b0; penn4 = 1'b1;
    psel0 = 1'b0; penn0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_mh4", {3'd0, v4}, 8'b0000_0010);
    check_eq("reset_mh0", {3'd0, v0}, 8'b0000_0010);

    // single request from A, then release
    step(1, 0); check_eq("a_turn", {3'd0, v4}, 8'b0000_0011);
    step(1, 0); check_eq("a_own", {3'd0, v4}, 8'b0001_0001);
    step(1, 0);
    step(0, 0); check_eq("a_release", {3'd0, v4}, 8'b0000_0010);

    // both from IDLE: A owned last, so B wins; handover back to A
    step(1, 1); check_eq("both_turn_b", {3'd0, v4}, 8'b0000_0111);
    step(1, 1); check_eq("both_own_b", {3'd0, v4}, 8'b0000_1101);
    step(1, 1);
    step(1, 1);
    step(1, 0); check_eq("hand_dead_a", {3'd0, v4}, 8'b0000_0011);
    step(1, 0); check_eq("hand_own_a", {3'd0, v4}, 8'b0001_0001);
    step(0, 0);
    step(1, 1); check_eq("rotate_b", {3'd0, v4}, 8'b0000_0111);
    step(1, 1);
    step(0, 0);
    step(0, 0);

    // preemption: A owns, B joins and both hold
    ga_cnt4 = 0; gb_cnt4 = 0; dead_cnt4 = 0; ga_cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i >= 2);
      ga_cnt4  += int'(ga4);
      gb_cnt4  += int'(gb4);
      dead_cnt4 += int'(enn4);
      ga_cnt0  += int'(ga0);
    end
    check_eq("preempt_ga_cycles", 8'(ga_cnt4), 8'd8);
    check_eq("preempt_gb_cycles", 8'(gb_cnt4), 8'd4);
    check_eq("preempt_dead_cycles", 8'(dead_cnt4), 8'd4);
    check_eq("nopreempt_ga_cycles", 8'(ga_cnt0), 8'd15);
    step(0, 1);
    step(0, 1);
    step(0, 0);
    step(0, 0);

    // request withdrawn in TURN
    step(0, 1); check_eq("pulse_turn_b", {3'd0, v4}, 8'b0000_0111);
    step(0, 0); check_eq("pulse_idle", {3'd0, v4}, 8'b0000_0110);
    step(0, 1);
    step(1, 0); check_eq("pulse_turn_a", {3'd0, v4}, 8'b0000_0011);
    step(1, 0); check_eq("pulse_own_a", {3'd0, v4}, 8'b0001_0001);

    // asynchronous reset while B owns
    step(0, 1);
    step(0, 1);
    step(0, 1);
    check_eq("pre_rst_gnt_b", {7'd0, gb4}, 8'd1);
    async_reset();
    step(1, 1); check_eq("post_rst_turn_a", {3'd0, v4}, 8'b0000_0011);
    step(1, 1); check_eq("post_rst_own_a", {3'd0, v4}, 8'b0001_0001);
    step(0, 0);
    step(0, 0);

    // random requests with persistence
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) ra = !ra;
      if ($urandom_range(0, 3) == 0) rb = !rb;
      step(ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
